// File: rtl/lns_lut_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lns_lut_stage_if
// Brief    : Request/response handshake bundle for the LNS lookup stage.
// Revision : 1.0
// ============================================================================
interface lns_lut_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        swap;

    modport master (
        output in_valid, d, sub, out_ready,
        input  in_ready, out_valid, result, swap
    );

    modport slave (
        input  in_valid, d, sub, out_ready,
        output in_ready, out_valid, result, swap
    );
endinterface
`default_nettype wire

// File: rtl/lns_lut_stage.sv
`default_nettype none
// ============================================================================
// Module   : lns_lut_stage
// Brief    : Gaussian-log (sb/db) correction lookup for the LNS add/sub path.
//            Macro LNS_LUT_INTERP_EN selects linear interpolation, else nearest.
// Revision : 1.0
// ============================================================================
module lns_lut_stage #(
    parameter int FRAC_BITS = 8,
    parameter int IDX_BITS  = 6
) (
    input  wire logic                clk_i,
    input  wire logic                rst_ni,
    lns_lut_stage_if.slave           bus,
    input  wire logic                tbl_we_i,
    input  wire logic                tbl_bank_i,
    input  wire logic [IDX_BITS-1:0] tbl_addr_i,
    input  wire logic [15:0]         tbl_data_i
);
    localparam int                  c_DEPTH   = 2 ** (IDX_BITS + 1);
    localparam logic [15:0]         c_SAT_LIM = 16'(1 << (FRAC_BITS + IDX_BITS));

`ifdef LNS_LUT_INTERP_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        CALC = 3'd3,
        HOLD = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        HOLD = 2'd2
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [15:0]           m_q;
    logic                  swap_q;
    logic                  sub_q;
    logic [15:0]           res_q;
    logic [15:0]           rdata_q;
    logic [15:0]           mem [c_DEPTH];

    logic                  w_rd_en;
    logic [IDX_BITS:0]     w_rd_addr;
    logic                  w_accept;
    logic [15:0]           w_mag;
    logic [IDX_BITS-1:0]   w_idx;
    logic                  w_sat;
    logic                  w_cancel;

    // 0x8000 negates to itself and lands in the saturated range
    assign w_mag    = bus.d[15] ? (~bus.d + 16'd1) : bus.d;
    assign w_idx    = m_q[FRAC_BITS +: IDX_BITS];
    assign w_sat    = (m_q >= c_SAT_LIM);
    assign w_cancel = sub_q && (m_q == 16'd0);
    assign w_accept = bus.in_valid && (state_q == IDLE);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.swap      = swap_q;

`ifdef LNS_LUT_INTERP_EN
    localparam logic [IDX_BITS-1:0] c_IDX_MAX = '1;
    localparam logic [IDX_BITS-1:0] c_IDX_ONE = IDX_BITS'(1);

    logic [15:0]           ta_q;
    logic [FRAC_BITS-1:0]  w_frac;
    logic [IDX_BITS-1:0]   w_idx_nxt;
    logic [15:0]           w_tb;
    logic signed [16:0]    w_diff;
    logic signed [25:0]    w_prod;
    logic signed [25:0]    w_sum;
    logic [9:0]            w_unused_sum;

    assign w_frac       = m_q[FRAC_BITS-1:0];
    assign w_idx_nxt    = w_idx + c_IDX_ONE;
    // Entry past the end of the bank is an implicit zero
    assign w_tb         = (w_idx == c_IDX_MAX) ? 16'h0000 : rdata_q;
    assign w_diff       = $signed({w_tb[15], w_tb}) - $signed({ta_q[15], ta_q});
    assign w_prod       = $signed({{9{w_diff[16]}}, w_diff})
                        * $signed({{(26-FRAC_BITS){1'b0}}, w_frac});
    assign w_sum        = $signed({{10{ta_q[15]}}, ta_q}) + (w_prod >>> FRAC_BITS);
    assign w_unused_sum = w_sum[25:16];
    assign bus.result   = res_q;
`else
    logic                  use_ram_q;
    logic [IDX_BITS:0]     w_n;

    assign w_n        = {1'b0, w_idx} + {{IDX_BITS{1'b0}}, m_q[FRAC_BITS-1]};
    assign bus.result = use_ram_q ? rdata_q : res_q;
`endif

    always_comb begin
        state_d   = state_q;
        w_rd_en   = 1'b0;
        w_rd_addr = {sub_q, w_idx};
        case (state_q)
            IDLE: if (bus.in_valid) state_d = RD_A;
`ifdef LNS_LUT_INTERP_EN
            RD_A: if (!tbl_we_i) begin
                w_rd_en = 1'b1;
                state_d = RD_B;
            end
            RD_B: if (!tbl_we_i) begin
                w_rd_en   = (w_idx != c_IDX_MAX);
                w_rd_addr = {sub_q, w_idx_nxt};
                state_d   = CALC;
            end
            CALC: state_d = HOLD;
`else
            RD_A: if (!tbl_we_i) begin
                w_rd_en   = !w_n[IDX_BITS];
                w_rd_addr = {sub_q, w_n[IDX_BITS-1:0]};
                state_d   = HOLD;
            end
`endif
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            m_q       <= '0;
            swap_q    <= 1'b0;
            sub_q     <= 1'b0;
            res_q     <= '0;
`ifdef LNS_LUT_INTERP_EN
            ta_q      <= '0;
`else
            use_ram_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                m_q    <= w_mag;
                swap_q <= bus.d[15];
                sub_q  <= bus.sub;
            end
`ifdef LNS_LUT_INTERP_EN
            if ((state_q == RD_B) && !tbl_we_i) ta_q <= rdata_q;
            if (state_q == CALC) begin
                res_q <= w_sat    ? 16'h0000 :
                         w_cancel ? 16'h8000 : w_sum[15:0];
            end
`else
            if ((state_q == RD_A) && !tbl_we_i) begin
                use_ram_q <= !(w_sat || w_cancel || w_n[IDX_BITS]);
                res_q     <= (w_cancel && !w_sat) ? 16'h8000 : 16'h0000;
            end
`endif
        end
    end

    // Table storage deliberately has no reset; writes win the single port
    always_ff @(posedge clk_i) begin
        if (tbl_we_i) mem[{tbl_bank_i, tbl_addr_i}] <= tbl_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      rdata_q <= '0;
        else if (w_rd_en) rdata_q <= mem[w_rd_addr];
    end
endmodule
`default_nettype wire

// File: tb/tb_lns_lut_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lns_lut_stage
// Brief    : Self-checking bench for lns_lut_stage (vectors, corner sequences,
//            randomized requests against an arithmetic reference model).
// Revision : 1.0
// ============================================================================
module tb_lns_lut_stage;
`ifdef LNS_LUT_INTERP_EN
    localparam int          c_LAT   = 4;
    localparam logic [15:0] c_R0580 = 16'h0038;
    localparam logic [15:0] c_R3F80 = 16'h0001;
`else
    localparam int          c_LAT   = 2;
    localparam logic [15:0] c_R0580 = 16'h0030;
    localparam logic [15:0] c_R3F80 = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tbl_we = 1'b0;
    logic        tbl_bank = 1'b0;
    logic [5:0]  tbl_addr = '0;
    logic [15:0] tbl_data = '0;

    lns_lut_stage_if bus ();

    lns_lut_stage dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .tbl_we_i   (tbl_we),
        .tbl_bank_i (tbl_bank),
        .tbl_addr_i (tbl_addr),
        .tbl_data_i (tbl_data)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mem_m [128];

    typedef struct {
        logic [15:0] d;
        logic        sub;
        logic [15:0] exp_res;
        logic        exp_swap;
        string       name;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: Gaussian-log correction computed directly from the table contents
    function automatic logic [16:0] model(input logic [15:0] dd, input logic ss);
        logic [15:0]        m;
        logic signed [15:0] t;
        int i, f, ta, tb, r, n;
        m = dd[15] ? (16'h0000 - dd) : dd;
        if (m >= 16'h4000) return {dd[15], 16'h0000};
        if (ss && (m == 16'h0000)) return {dd[15], 16'h8000};
        i = int'(m) / 256;
        f = int'(m) % 256;
`ifdef LNS_LUT_INTERP_EN
        t  = mem_m[(ss ? 64 : 0) + i];
        ta = t;
        if (i == 63) tb = 0;
        else begin
            t  = mem_m[(ss ? 64 : 0) + i + 1];
            tb = t;
        end
        r = ta + (((tb - ta) * f) >>> 8);
`else
        n = i + ((f >= 128) ? 1 : 0);
        r = (n == 64) ? 0 : int'(mem_m[(ss ? 64 : 0) + n]);
`endif
        return {dd[15], r[15:0]};
    endfunction

    task automatic twrite(input logic bank, input logic [5:0] addr, input logic [15:0] data);
        tbl_we = 1'b1; tbl_bank = bank; tbl_addr = addr; tbl_data = data;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        mem_m[{bank, addr}] = data;
    endtask

    task automatic wait_ready(input string nm);
        int g;
        g = 0;
        while (!bus.in_ready && g < 20) begin @(posedge clk); #1; g++; end
        if (g >= 20) chk({nm, "_ready_timeout"}, 32'(g), 32'd0);
    endtask

    // One full request; optionally collides a table write with the first read cycle
    task automatic run_req(input logic [15:0] dd, input logic ss, input logic [15:0] er,
                           input logic es, input int el, input string nm, input bit collide);
        int lat;
        wait_ready(nm);
        bus.in_valid = 1'b1; bus.d = dd; bus.sub = ss;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        if (collide) begin
            twrite(1'b0, 6'd5, 16'h0050);
            lat++;
        end
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({nm, "_lat"}, 32'(lat), 32'(el));
        chk({nm, "_res"}, 32'(bus.result), 32'(er));
        chk({nm, "_swap"}, 32'(bus.swap), 32'(es));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        logic [31:0] rv;
        logic [15:0] dd;
        logic        ss;
        logic [16:0] ex;

        bus.in_valid = 1'b0; bus.d = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        vecs[0] = '{16'h0580, 1'b0, c_R0580, 1'b0, "interp_0580"};
        vecs[1] = '{16'hFA80, 1'b0, c_R0580, 1'b1, "neg_FA80"};
        vecs[2] = '{16'h3F80, 1'b0, c_R3F80, 1'b0, "edge_3F80"};
        vecs[3] = '{16'h4000, 1'b0, 16'h0000, 1'b0, "sat_4000"};
        vecs[4] = '{16'h8000, 1'b0, 16'h0000, 1'b1, "sat_8000"};
        vecs[5] = '{16'h0000, 1'b1, 16'h8000, 1'b0, "cancel"};
        vecs[6] = '{16'h0500, 1'b0, 16'h0040, 1'b0, "exact_0500"};
        vecs[7] = '{16'hC000, 1'b1, 16'h0000, 1'b1, "sat_C000_db"};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {14'd0, bus.in_ready, bus.out_valid, bus.swap, bus.result},
            {14'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 128; k++) begin
            rv = $urandom;
            twrite(k[6], k[5:0], rv[15:0]);
        end
        twrite(1'b0, 6'd5, 16'h0040);
        twrite(1'b0, 6'd6, 16'h0030);
        twrite(1'b0, 6'd63, 16'h0002);
        twrite(1'b1, 6'd0, 16'hF800);

        for (int k = 0; k < 8; k++)
            run_req(vecs[k].d, vecs[k].sub, vecs[k].exp_res, vecs[k].exp_swap, c_LAT,
                    vecs[k].name, 1'b0);

        // Backpressure: result held, new request ignored while in HOLD
        begin
            int g;
            wait_ready("bp");
            bus.in_valid = 1'b1; bus.d = 16'h0580; bus.sub = 1'b0;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            g = 0;
            while (!bus.out_valid && g < 40) begin @(posedge clk); #1; g++; end
            for (int c = 0; c < 3; c++) begin
                chk("bp_hold", {13'd0, bus.out_valid, bus.in_ready, bus.swap, bus.result},
                    {13'd0, 1'b1, 1'b0, 1'b0, c_R0580});
                bus.in_valid = 1'b1; bus.d = 16'h4000;
                @(posedge clk); #1;
            end
            chk("bp_hold_end", {15'd0, bus.out_valid, bus.result}, {15'd0, 1'b1, c_R0580});
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("bp_release_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        end

        // Asynchronous reset one cycle into the read sequence
        wait_ready("rst");
        bus.in_valid = 1'b1; bus.d = 16'h0580; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_midop", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_req(16'h0500, 1'b0, 16'h0040, 1'b0, c_LAT, "after_rst", 1'b0);

        run_req(16'h0500, 1'b0, 16'h0050, 1'b0, c_LAT + 1, "collide", 1'b1);

        for (int k = 0; k < 40; k++) begin
            rv = $urandom;
            dd = (k % 4 == 3) ? rv[15:0] : {{2{rv[17]}}, rv[13:0]};
            ss = rv[20];
            ex = model(dd, ss);
            run_req(dd, ss, ex[15:0], ex[16], c_LAT, $sformatf("rand%0d_d%h_s%0d", k, dd, ss), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lns_lut_stage.md
# lns_lut_stage

Lookup stage for the logarithmic-number-system add/subtract path. It sits between register read and execute. It takes the operand log-difference d (T − S) and returns the Gaussian-log correction term: sb(|d|) for same-sign add, db(|d|) for opposite-sign subtract. The execute stage adds this term to the larger operand. Tables live in a single-port synchronous RAM, and a small FSM sequences the reads, optional linear interpolation and an output handshake.

## Interface
- FRAC_BITS, 8: fractional bits of the log fixed-point format (Q7.8).
- IDX_BITS, 6: table index width, 64 entries per bank.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- d  input  16  two's-complement log difference (T − S), Q7.8.
- sub  input  1  0 selects the sb bank (add), 1 selects the db bank (subtract).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  16  correction term in LNS log format.
- swap  output  1  1 when d was negative, meaning S is the larger operand.
- tbl_we  input  1  table write strobe.
- tbl_bank  input  1  bank for the write (0 = sb, 1 = db).
- tbl_addr  input  6  entry index.
- tbl_data  input  16  entry value.

## Operation
- States: IDLE, RD_A, RD_B, CALC, HOLD.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in HOLD.
- On accept (in_valid & in_ready):
  - Latch m = |d|, swap = d[15] and sub.
  - d = 0x8000 gives m = 0x8000, which is treated as saturated.
- Index and fraction: i = m[13:8], f = m[7:0]. Saturated means m ≥ 0x4000.
- Special cases: the table is still sequenced, for fixed latency, but the table value is overridden.
  - Saturated gives result 0x0000.
  - sub = 1 with m = 0 gives result 0x8000 (LNS zero, exact cancellation).
- Interpolation (macro defined):
  - RD_A reads T[i]; RD_B reads T[i+1].
  - At i = 63, T[64] is an implicit 0x0000 and no read is issued.
  - CALC computes result = T[i] + ((T[i+1] − T[i]) · f) >>> 8.
    - Difference is signed 17-bit; product is signed 25-bit; shift is arithmetic.
    - Sum is truncated to 16 bits.
- Nearest (macro undefined):
  - RD_A reads T[n] with n = i + f[7]; RD_B and CALC are skipped.
  - n = 64 gives 0x0000.
- HOLD holds result and swap stable until out_ready, then returns to IDLE.
- Table writes:
  - Accepted in any state and have priority over a same-cycle read port use.
  - The FSM stalls that cycle in RD_A/RD_B and retries the read next cycle.
  - Contents are never cleared by reset.
  - Unwritten entries read as X in simulation.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0x0000, swap = 0.
- Latency from the accept edge to out_valid high, with no write stalls:
  - Interpolation: 4 cycles (RD_A, RD_B, CALC, HOLD).
  - Nearest: 2 cycles (RD_A, HOLD).
- Each tbl_we pulse in RD_A/RD_B adds 1 cycle.
- Throughput: one request in flight. The next request is accepted on the cycle after the HOLD & out_ready handshake; there is no overlap.
- Table RAM read is synchronous: address issued in cycle N, data usable in cycle N+1.
- Write then read of the same entry on the next cycle returns the new data.
- Reset asserted mid-operation:
  - The FSM returns to IDLE and out_valid drops immediately (asynchronous).
  - The in-flight request is discarded.
  - Table contents are preserved.
- out_ready high outside HOLD is ignored.

## Configuration
- LNS_LUT_INTERP_EN:
  - Defined: linear interpolation between adjacent entries, 4-cycle latency, and a multiplier in CALC.
  - Undefined: nearest-entry lookup (round half up on f[7]), 2-cycle latency, and the RD_B/CALC states and the multiplier are removed.

## Test plan
Preload for all scenarios: sb[5] = 0x0040, sb[6] = 0x0030, sb[63] = 0x0002, db[0] = 0xF800.

- Interpolation: d = 0x0580, sub = 0.
  - Interp build: result = 0x0038, swap = 0, out_valid 4 cycles after accept.
  - Nearest build: result = 0x0030 at 2 cycles.
- Negative and edge index:
  - d = 0xFA80, sub = 0: result 0x0038 (interp), swap = 1.
  - d = 0x3F80: interp result = 0x0001; nearest result = 0x0000.
- Saturation and cancellation:
  - d = 0x4000: result 0x0000.
  - d = 0x8000: result 0x0000, swap = 1.
  - d = 0x0000 with sub = 1: result 0x8000.
- Backpressure: hold out_ready = 0 for 3 cycles in HOLD.
  - result and swap stay stable, in_ready = 0, and a new in_valid is ignored.
  - Release out_ready: IDLE next cycle.
- Write collision: pulse tbl_we in RD_A writing sb[5] = 0x0050, with d = 0x0500 in flight.
  - Latency grows by 1 and result = 0x0050.
- Reset mid-op: assert reset in RD_B.
  - out_valid = 0 and in_ready = 1 immediately.
  - After release, d = 0x0500 returns the preloaded sb[5].
